fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I pipeline. Holds the program counter and issues in-order word requests to instruction memory over a request/grant/response interface. Buffers returned instructions with their PCs in a small queue toward the IF/ID boundary. Consumes the branch unit's taken/target outputs from EX as a redirect that flushes all younger fetch state.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- DEPTH, 4, fetch queue entries; power of two, ≥2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_i  in  1  EX branch taken (JAL, JALR, or taken conditional).
- redirect_pc_i  in  32  EX branch target.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address; bits [1:0] always 0.
- imem_gnt_i  in  1  request accepted this cycle (valid only while imem_req_o=1).
- imem_rvalid_i  in  1  response valid; responses return in grant order, ≥1 cycle after grant.
- imem_rdata_i  in  32  instruction word.
- if_valid_o  out  1  head entry holds a valid instruction.
- if_pc_o  out  32  PC of head entry.
- if_instr_o  out  32  instruction of head entry.
- if_ready_i  in  1  ID accepts head; pop when if_valid_o & if_ready_i.

## Operation
- State: fetch_pc; queue of DEPTH slots (pc, instr, filled); head/tail/alloc pointers; drop_cnt (granted responses still owed that must be discarded).
- Allocation at grant: a slot is reserved on imem_req_o & imem_gnt_i. The slot's pc is set to fetch_pc, and fetch_pc advances by 4 (32-bit wrap from 32'hFFFF_FFFC to 0).
- imem_req_o = (reserved+filled slots < DEPTH). imem_addr_o = {fetch_pc[31:2],2'b00}. Both depend on registered state only; no combinational path from redirect_i, if_ready_i, or imem_gnt_i.
- Response, normal case: on imem_rvalid_i with drop_cnt=0, the oldest reserved-unfilled slot takes imem_rdata_i and sets filled.
- Response, drop case: on imem_rvalid_i with drop_cnt>0, the data is discarded and drop_cnt decrements.
- Output: if_valid_o = head slot filled. if_pc_o and if_instr_o come from the head slot. A pop frees the head slot.
- Redirect (redirect_i=1) does all of the following:
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}.
  - All slots are invalidated and pointers reset.
  - drop_cnt <= (drop_cnt + unfilled reserved slots + grant_this_cycle − rvalid_this_cycle); the result is never negative.
- Same-cycle events:
  - Redirect wins over pop, grant, and fill. A grant in a redirect cycle allocates nothing and adds to drop_cnt.
  - An rvalid in a redirect cycle is discarded.
  - Pop and fill of different slots in one cycle are both honoured.
  - A pop in a full cycle frees its slot from the next cycle only.
- drop_cnt width is clog2(DEPTH)+2 bits. Outstanding responses never exceed DEPTH + previous drop_cnt. Saturation is an assertion failure, not a design case.

## Timing
- Reset values (asynchronous): fetch_pc=RESET_PC, queue empty, drop_cnt=0, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0.
- After rst_n deasserts: imem_req_o=1 with addr RESET_PC on the first clock edge following release.
- Redirect latency: redirect_i at cycle N gives imem_addr_o=target and imem_req_o=1 at N+1. if_valid_o=0 from N+1 until the target's response is written.
- Fill-to-output latency: response at cycle T gives if_valid_o at T+1, registered with no bypass.
- Throughput: with gnt always high, 1-cycle memory latency, and if_ready_i=1, sustained throughput is one instruction per cycle for DEPTH≥3.
- If if_ready_i is held at 0, requests stop once DEPTH slots are reserved or filled. The head holds stable until popped or flushed.
- Reset asserted mid-operation clears all state immediately. Responses arriving while rst_n=0 are ignored. The bench must not deliver responses for pre-reset grants after reset release.

## Test plan
- Reset: rst_n low then released, gnt=1, 1-cycle memory -> first imem_addr_o=0x0, if_pc_o sequence 0x0,0x4,0x8,… one per cycle; if_instr_o matches memory.
- Backpressure: if_ready_i=0 for 10 cycles -> exactly 4 grants, imem_req_o drops to 0, head PC 0x0 stable. Release -> PCs 0x0..0xC then 0x10 with no gap.
- Redirect with 2 in-flight: 3-cycle memory, redirect_i=1 with redirect_pc_i=0x100 -> two stale responses discarded, next if_valid_o shows PC 0x100; no stale PC ever appears at the output.
- Simultaneous events: redirect_i, imem_gnt_i, and imem_rvalid_i all high in one cycle, target 0x203 -> fetch resumes at 0x200, drop_cnt accounting correct, first output PC 0x200.
- Wrap: redirect to 0xFFFF_FFF8 -> output PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Mid-run reset: assert rst_n with a full queue -> all outputs at reset values in the same cycle; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Owns the PC, issues in-order word
// requests over a req/gnt/rvalid interface, queues returned instructions with
// their PCs toward ID, and flushes all younger state on an EX redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        if_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = PW + 2;
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    alloc_ptr;
  logic [CW-1:0]    occ_cnt;
  logic [CW-1:0]    pend_cnt;
  logic [DW-1:0]    drop_cnt;
  logic             req_q;

  logic             grant;
  logic             pop;
  logic             resp_fill;
  logic             resp_drop;
  logic [CW-1:0]    occ_nxt;
  logic [DW-1:0]    drop_flush;

  always_comb begin
    imem_req_o  = req_q;
    imem_addr_o = fetch_pc;
    if_valid_o  = filled_q[head_ptr];
    if_pc_o     = filled_q[head_ptr] ? pc_q[head_ptr]    : '0;
    if_instr_o  = filled_q[head_ptr] ? instr_q[head_ptr] : '0;
  end

  always_comb begin
    grant      = req_q & imem_gnt_i;
    pop        = filled_q[head_ptr] & if_ready_i;
    resp_fill  = imem_rvalid_i & (drop_cnt == '0);
    resp_drop  = imem_rvalid_i & (drop_cnt != '0);
    occ_nxt    = occ_cnt + CW'(grant) - CW'(pop);
    drop_flush = drop_cnt + DW'(pend_cnt) + DW'(grant) - DW'(imem_rvalid_i);
  end

  // Slot payload only; validity is tracked by filled_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!redirect_i) begin
      if (grant)     pc_q[alloc_ptr]   <= fetch_pc;
      if (resp_fill) instr_q[fill_ptr] <= imem_rdata_i;
    end
  end

  // req is registered from next-cycle occupancy so it never depends on inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC_A;
      req_q     <= 1'b0;
      filled_q  <= '0;
      head_ptr  <= '0;
      fill_ptr  <= '0;
      alloc_ptr <= '0;
      occ_cnt   <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect_i) begin
      fetch_pc  <= redirect_pc_i & 32'hFFFF_FFFC;
      req_q     <= 1'b1;
      filled_q  <= '0;
      head_ptr  <= '0;
      fill_ptr  <= '0;
      alloc_ptr <= '0;
      occ_cnt   <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_flush;
    end else begin
      req_q    <= (occ_nxt < CW'(DEPTH));
      occ_cnt  <= occ_nxt;
      pend_cnt <= pend_cnt + CW'(grant) - CW'(resp_fill);
      if (grant) begin
        alloc_ptr <= alloc_ptr + PW'(1);
        fetch_pc  <= fetch_pc + 32'd4;
      end
      if (resp_fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (resp_drop) drop_cnt <= drop_cnt - DW'(1);
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= head_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit with an in-order
// instruction memory model and an expected-PC-stream reference.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_ready_i    (if_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } resp_t;

  resp_t       pend_q[$];
  longint      edge_no  = 1;
  longint      last_due = 0;
  logic [31:0] mem_seed;

  // stimulus knobs
  bit          rst_knob      = 1'b0;
  bit          ready_knob    = 1'b1;
  bit          ready_rand    = 1'b0;
  bit          gnt_knob      = 1'b1;
  bit          gnt_rand      = 1'b0;
  int unsigned lat_min       = 1;
  int unsigned lat_max       = 1;
  bit          redir_knob    = 1'b0;
  logic [31:0] redir_pc_knob = '0;

  // what will happen at the upcoming edge
  bit          o_gnt;
  logic [31:0] o_gnt_addr;
  bit          o_pop;
  logic [31:0] o_pop_pc;
  logic [31:0] o_pop_instr;
  bit          o_redir;
  bit          o_rvalid;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // One clock of stimulus and memory behaviour, driven at the falling edge.
  task automatic step_cycle();
    resp_t  r;
    longint due;
    @(negedge clk);
    rst_n         = rst_knob;
    redirect_i    = redir_knob;
    redirect_pc_i = redir_pc_knob;
    redir_knob    = 1'b0;
    if_ready_i    = ready_rand ? ($urandom_range(0, 1) == 1) : ready_knob;
    imem_gnt_i    = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_knob;
    o_redir  = redirect_i;
    o_gnt    = 1'b0;
    o_pop    = 1'b0;
    o_rvalid = 1'b0;
    if (!rst_n) begin
      pend_q.delete();
      last_due      = 0;
      imem_rvalid_i = ($urandom_range(0, 1) == 1);
      imem_rdata_i  = $urandom;
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        o_gnt      = 1'b1;
        o_gnt_addr = imem_addr_o;
        due = edge_no + longint'($urandom_range(lat_min, lat_max));
        if (due < last_due) due = last_due;
        last_due = due;
        r.addr = imem_addr_o;
        r.due  = due;
        pend_q.push_back(r);
      end
      if (pend_q.size() != 0 && pend_q[0].due <= edge_no) begin
        r = pend_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = memf(r.addr);
        o_rvalid      = 1'b1;
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
      end
      if (if_valid_o && if_ready_i && !redirect_i) begin
        o_pop       = 1'b1;
        o_pop_pc    = if_pc_o;
        o_pop_instr = if_instr_o;
      end
    end
    edge_no++;
  endtask

  task automatic do_reset();
    rst_knob = 1'b0;
    repeat (3) step_cycle();
    rst_knob = 1'b1;
    step_cycle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    int          npops;
    int          gaps;
    bit          started;
    gnt_knob = 1; gnt_rand = 0; ready_knob = 1; ready_rand = 0;
    lat_min = 1; lat_max = 1;
    rst_knob = 1'b0;
    repeat (3) step_cycle();
    checks++;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req_o); end
    checks++;
    if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h want=0", imem_addr_o); end
    checks++;
    if (if_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", if_valid_o); end
    checks++;
    if (if_pc_o !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h want=0", if_pc_o); end
    checks++;
    if (if_instr_o !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h want=0", if_instr_o); end
    rst_knob = 1'b1;
    step_cycle();
    checks++;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rel_req_early got=%b want=0", imem_req_o); end
    step_cycle();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || !o_gnt)
      begin failures++; $display("FAIL first_req req=%b addr=%h want req=1 addr=0", imem_req_o, imem_addr_o); end
    exp_pc = 32'h0; npops = 0; gaps = 0; started = 0;
    repeat (20) begin
      step_cycle();
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc)) begin
          failures++;
          $display("FAIL reset_stream pc=%h instr=%h want pc=%h instr=%h", o_pop_pc, o_pop_instr, exp_pc, memf(exp_pc));
        end
        exp_pc += 32'd4; npops++; started = 1;
      end else if (started) gaps++;
    end
    checks++;
    if (gaps != 0 || npops < 15) begin failures++; $display("FAIL throughput pops=%0d gaps=%0d want pops>=15 gaps=0", npops, gaps); end
  endtask

  task automatic test_backpressure();
    int          ngnt;
    int          unstable;
    logic [31:0] exp_pc;
    ready_knob = 0; gnt_knob = 1; lat_min = 1; lat_max = 1;
    do_reset();
    ngnt = 0; unstable = 0;
    repeat (10) begin
      step_cycle();
      if (o_gnt) ngnt++;
      if (if_valid_o && if_pc_o !== 32'h0) unstable++;
    end
    checks++;
    if (ngnt != DEPTH) begin failures++; $display("FAIL bp_grants got=%0d want=%0d", ngnt, DEPTH); end
    checks++;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req got=%b want=0", imem_req_o); end
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== memf(32'h0) || unstable != 0)
      begin failures++; $display("FAIL bp_head valid=%b pc=%h unstable=%0d want valid=1 pc=0 unstable=0", if_valid_o, if_pc_o, unstable); end
    ready_knob = 1;
    exp_pc = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      checks++;
      if (!o_pop || o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc))
        begin failures++; $display("FAIL bp_release pop=%b pc=%h want pop=1 pc=%h", o_pop, o_pop_pc, exp_pc); end
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_redirect();
    int          ngnt;
    int          npops;
    logic [31:0] exp_pc;
    ready_knob = 1; gnt_knob = 1; lat_min = 3; lat_max = 3;
    do_reset();
    ngnt = 0;
    repeat (2) begin step_cycle(); if (o_gnt) ngnt++; end
    checks++;
    if (ngnt != 2) begin failures++; $display("FAIL redir_inflight got=%0d want=2", ngnt); end
    gnt_knob = 0;
    redir_knob = 1; redir_pc_knob = 32'h100;
    step_cycle();
    gnt_knob = 1;
    step_cycle();
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || if_valid_o !== 1'b0)
      begin failures++; $display("FAIL redir_next req=%b addr=%h valid=%b want 1/100/0", imem_req_o, imem_addr_o, if_valid_o); end
    exp_pc = 32'h100; npops = 0;
    repeat (16) begin
      step_cycle();
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc))
          begin failures++; $display("FAIL redir_stream pc=%h instr=%h want pc=%h instr=%h", o_pop_pc, o_pop_instr, exp_pc, memf(exp_pc)); end
        exp_pc += 32'd4; npops++;
      end
    end
    checks++;
    if (npops < 5) begin failures++; $display("FAIL redir_progress pops=%0d want>=5", npops); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_pc;
    logic [31:0] exp_f;
    int          npops;
    ready_knob = 1; gnt_knob = 1; lat_min = 2; lat_max = 2;
    do_reset();
    repeat (8) step_cycle();
    redir_knob = 1; redir_pc_knob = 32'h203;
    step_cycle();
    checks++;
    if (!o_gnt || !o_rvalid || !o_redir)
      begin failures++; $display("FAIL simul_setup gnt=%b rvalid=%b want 1/1", o_gnt, o_rvalid); end
    step_cycle();
    checks++;
    if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1 || if_valid_o !== 1'b0)
      begin failures++; $display("FAIL simul_next addr=%h req=%b valid=%b want 200/1/0", imem_addr_o, imem_req_o, if_valid_o); end
    exp_pc = 32'h200; exp_f = 32'h200; npops = 0;
    if (o_gnt) begin
      checks++;
      if (o_gnt_addr !== exp_f) begin failures++; $display("FAIL simul_gnt addr=%h want=%h", o_gnt_addr, exp_f); end
      exp_f += 32'd4;
    end
    repeat (16) begin
      step_cycle();
      if (o_gnt) begin
        checks++;
        if (o_gnt_addr !== exp_f) begin failures++; $display("FAIL simul_gnt addr=%h want=%h", o_gnt_addr, exp_f); end
        exp_f += 32'd4;
      end
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc))
          begin failures++; $display("FAIL simul_stream pc=%h instr=%h want pc=%h instr=%h", o_pop_pc, o_pop_instr, exp_pc, memf(exp_pc)); end
        exp_pc += 32'd4; npops++;
      end
    end
    checks++;
    if (npops < 8) begin failures++; $display("FAIL simul_progress pops=%0d want>=8", npops); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    int          npops;
    ready_knob = 1; gnt_knob = 1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) step_cycle();
    redir_knob = 1; redir_pc_knob = 32'hFFFF_FFF8;
    step_cycle();
    exp_pc = 32'hFFFF_FFF8; npops = 0;
    repeat (12) begin
      step_cycle();
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc))
          begin failures++; $display("FAIL wrap_stream pc=%h want=%h", o_pop_pc, exp_pc); end
        exp_pc += 32'd4; npops++;
      end
    end
    checks++;
    if (npops < 4) begin failures++; $display("FAIL wrap_progress pops=%0d want>=4", npops); end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] exp_pc;
    logic [31:0] exp_f;
    int          npops;
    int          ngnt;
    ready_knob = 0; gnt_knob = 1; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (8) step_cycle();
    checks++;
    if (if_valid_o !== 1'b1 || imem_req_o !== 1'b0)
      begin failures++; $display("FAIL mid_full valid=%b req=%b want 1/0", if_valid_o, imem_req_o); end
    rst_knob = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0)
      begin failures++; $display("FAIL mid_reset req=%b addr=%h valid=%b pc=%h instr=%h want all 0", imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o); end
    repeat (3) step_cycle();
    ready_knob = 1;
    rst_knob = 1'b1;
    step_cycle();
    exp_pc = 32'h0; exp_f = 32'h0; npops = 0; ngnt = 0;
    repeat (12) begin
      step_cycle();
      if (o_gnt) begin
        checks++;
        if (o_gnt_addr !== exp_f) begin failures++; $display("FAIL mid_gnt addr=%h want=%h", o_gnt_addr, exp_f); end
        exp_f += 32'd4; ngnt++;
      end
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_pc || o_pop_instr !== memf(exp_pc))
          begin failures++; $display("FAIL mid_stream pc=%h want=%h", o_pop_pc, exp_pc); end
        exp_pc += 32'd4; npops++;
      end
    end
    checks++;
    if (npops < 6 || ngnt < 6) begin failures++; $display("FAIL mid_progress pops=%0d grants=%0d want>=6", npops, ngnt); end
  endtask

  task automatic test_random();
    logic [31:0] exp_f;
    logic [31:0] exp_p;
    logic [31:0] tgt;
    logic [31:0] prev_tgt;
    bit          prev_redir;
    int          npops;
    gnt_rand = 1; ready_rand = 1; lat_min = 1; lat_max = 4;
    do_reset();
    exp_f = 32'h0; exp_p = 32'h0; prev_redir = 0; prev_tgt = '0; tgt = '0; npops = 0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        tgt = $urandom;
        redir_knob = 1; redir_pc_knob = tgt;
      end
      step_cycle();
      if (prev_redir) begin
        checks++;
        if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== {prev_tgt[31:2], 2'b00})
          begin failures++; $display("FAIL rand_redir valid=%b req=%b addr=%h want 0/1/%h", if_valid_o, imem_req_o, imem_addr_o, {prev_tgt[31:2], 2'b00}); end
      end
      if (o_gnt) begin
        checks++;
        if (o_gnt_addr !== exp_f) begin failures++; $display("FAIL rand_gnt addr=%h want=%h", o_gnt_addr, exp_f); end
        exp_f += 32'd4;
      end
      if (o_pop) begin
        checks++;
        if (o_pop_pc !== exp_p || o_pop_instr !== memf(exp_p))
          begin failures++; $display("FAIL rand_pop pc=%h instr=%h want pc=%h instr=%h", o_pop_pc, o_pop_instr, exp_p, memf(exp_p)); end
        exp_p += 32'd4; npops++;
      end
      if (o_redir) begin
        exp_f = {tgt[31:2], 2'b00};
        exp_p = {tgt[31:2], 2'b00};
      end
      prev_redir = o_redir;
      prev_tgt   = tgt;
    end
    checks++;
    if (npops < 200) begin failures++; $display("FAIL rand_progress pops=%0d want>=200", npops); end
    gnt_rand = 0; ready_rand = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    if_ready_i = 1'b0;
    mem_seed = $urandom;
    #0 rst_n = 1'b0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_wrap();
    test_midrun_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
